fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Decoupled RV32I instruction fetch stage. Replaces the free-running pc + next_pc mux in top.
//  Issues pipelined requests to instruction memory with a valid/ready handshake.
//  Buffers in-order responses, tagged with their PC, in a FIFO_DEPTH-entry prefetch queue
//  that feeds decode via valid/ready. Branch/jump redirects flush the queue and discard
//  stale in-flight responses.
// PARAMETERS
//  XLEN          32   address/PC width
//  ILEN          32   instruction width
//  RESET_PC      '0   PC fetched first after reset
//  FIFO_DEPTH    4    prefetch queue entries (power of 2, >=2)
//  MAX_INFLIGHT  4    max outstanding memory requests, including ones marked for drop (>=1)
// PORTS
//  clk             in   1     clock, all state on rising edge
//  areset_n        in   1     asynchronous active-low reset
//  fetch_en        in   1     1 = new requests may be issued; 0 = stop issuing, keep draining
//  redirect_valid  in   1     redirect fetch stream (taken branch/jump)
//  redirect_pc     in   XLEN  new PC; bits[1:0] ignored, treated as 0
//  req_valid       out  1     memory request valid
//  req_ready       in   1     memory accepts request
//  req_addr        out  XLEN  request address
//  rsp_valid       in   1     in-order response (no backpressure)
//  rsp_data        in   ILEN  response instruction word
//  instr_valid     out  1     queue head valid
//  instr_ready     in   1     decode accepts head
//  instr           out  ILEN  head instruction
//  instr_pc        out  XLEN  PC of head instruction
// BEHAVIOUR
//  State: fetch_pc, rsp_pc, inflight, drop_cnt, queue (count, rd/wr ptr).
//  Reset (async): fetch_pc = rsp_pc = RESET_PC; inflight = drop_cnt = count = 0.
//   Reset also forces req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
//  Issue: req_valid = fetch_en & !redirect_valid & inflight < MAX_INFLIGHT
//   & count + (inflight - drop_cnt) < FIFO_DEPTH (credit rule; the queue can never overflow).
//   req_addr = fetch_pc. On req_valid & req_ready: fetch_pc += 4 (wraps modulo 2^XLEN).
//  Response:
//   if drop_cnt != 0: discard, drop_cnt -= 1.
//   else push {rsp_pc, rsp_data}, rsp_pc += 4.
//   Every response decrements inflight; issue and response in the same cycle leave it unchanged.
//  Latency: data pushed at edge N gives instr_valid = 1 after edge N. No rsp->instr bypass.
//  Pop: on instr_valid & instr_ready, count -= 1. Push and pop in the same cycle: count unchanged.
//   This also holds when the queue is full.
//  Outputs are read from the queue head, stable while instr_valid & !instr_ready.
//  Redirect (redirect_valid = 1 at edge):
//   - queue cleared (count = 0); instr_valid forced 0 in the redirect cycle.
//   - no request issued that cycle.
//   - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
//   - drop_cnt = inflight - rsp_valid: every response still owed is stale.
//   - a response arriving in the redirect cycle is discarded.
//   - a pop in the redirect cycle is void.
//  Back-to-back redirects: the last one wins; drop_cnt recomputed each time.
//   The MAX_INFLIGHT bound keeps inflight and drop_cnt within range.
//  fetch_en = 0 mid-stream: outstanding responses still retire; queue still drains.
//  Reset mid-operation: all state returns to reset values immediately.
//   The memory side must not deliver responses for pre-reset requests.
//  Counters are $clog2(MAX_INFLIGHT+1) and $clog2(FIFO_DEPTH+1) bits; never wrap.
// TESTING
//  1 Reset, fetch_en=1, req_ready=1, 1-cycle memory, instr_ready=1
//    -> req_addr 0,4,8,...; instr_pc 0,4,8 on consecutive cycles, instr matches memory.
//  2 instr_ready=0, fetch_en=1, DEPTH=4
//    -> exactly 4 requests issued, then req_valid stays 0; count=4.
//    Then instr_ready=1 -> issue resumes, no word lost or duplicated.
//  3 3 requests in flight (3-cycle latency), redirect_pc=0x103
//    -> drop_cnt=3, next req_addr=0x100.
//    The 3 stale responses are discarded; first instr_pc=0x100.
//  4 Redirect in the same cycle as rsp_valid and a pop
//    -> response and pop ignored, count=0, drop_cnt=inflight-1.
//    Two consecutive redirects (0x200 then 0x300) -> first instr_pc=0x300.
//  5 req_ready toggled randomly, memory latency 1-5 cycles, random redirects
//    -> instr_pc sequence matches a scoreboard model.
//    Never more than MAX_INFLIGHT outstanding; queue never overflows.
//  6 fetch_pc=0xFFFF_FFFC -> next req_addr 0x0000_0000.
//    areset_n pulsed mid-stream -> instr_valid=0, req_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Decoupled RV32I instruction fetch: pipelined memory requests, in-order responses buffered
// with their PC in a small prefetch queue, and redirects that flush the queue and drop stale responses.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     FIFO_DEPTH   = 4,
    parameter int unsigned     MAX_INFLIGHT = 4
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [ILEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = ((IW > CW) ? IW : CW) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [IW-1:0]   inflight;
    logic [IW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic [ILEN-1:0] q_data [FIFO_DEPTH];
    logic [XLEN-1:0] q_pc   [FIFO_DEPTH];

    logic [XLEN-1:0] redirect_aligned;
    logic [SW-1:0]   credit_used;
    logic            issue;
    logic            push;
    logic            pop;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Queue slots already occupied plus those promised to live (non-dropped) responses.
    assign credit_used = SW'(count) + SW'(inflight) - SW'(drop_cnt);

    assign req_valid = areset_n & fetch_en & ~redirect_valid
                     & (inflight < IW'(MAX_INFLIGHT))
                     & (credit_used < SW'(FIFO_DEPTH));
    assign req_addr  = fetch_pc;
    assign issue     = req_valid & req_ready;

    assign push = rsp_valid & ~redirect_valid & (drop_cnt == '0);

    assign instr_valid = areset_n & (count != '0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign instr       = instr_valid ? q_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr]   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            inflight <= inflight - IW'(rsp_valid);
            drop_cnt <= inflight - IW'(rsp_valid);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - IW'(1);
            end
            inflight <= inflight + IW'(issue) - IW'(rsp_valid);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
